// File: rtl/alu_pkg.sv
// Shared definitions for the Y86-64 execute-stage ALU: default width and
// the operation select codes driven by the execute stage.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Combinational shared adder/subtractor: computes a + b or a - b depending
// on sub_en and reports signed two's-complement overflow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             sub_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] cin_ext;

  // Subtraction is a + ~b + 1; the carry-in rides in as the LSB of a vector.
  assign b_eff   = b ^ {WIDTH{sub_en}};
  assign cin_ext = {{(WIDTH-1){1'b0}}, sub_en};
  assign sum     = a + b_eff + cin_ext;

  // Same-sign operands into the adder producing an opposite-sign sum.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu_64.sv
// Registered 64-bit ALU for the Y86-64 execute stage: add/sub/and/xor with
// a signed-overflow flag, one cycle of latency, synchronous reset.
module alu_64
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ans,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] ans_d, ans_q;
  logic             overflow_d, overflow_q;

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .sub_en  (control[0]),
    .a       (a),
    .b       (b),
    .sum     (sum),
    .overflow(sum_ovf)
  );

  always_comb begin
    ans_d      = '0;
    overflow_d = 1'b0;
    unique case (control)
      ALU_ADD,
      ALU_SUB: begin
        ans_d      = sum;
        overflow_d = sum_ovf;
      end
      ALU_AND: ans_d = a & b;
      ALU_XOR: ans_d = a ^ b;
      default: ans_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      ans_q      <= ans_d;
      overflow_q <= overflow_d;
    end
  end

  assign ans      = ans_q;
  assign overflow = overflow_q;

endmodule : alu_64

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against a wide-integer reference model.
module tb_alu_64;

  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  control;
  logic [63:0] a, b;
  logic [63:0] ans;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_ans;
  logic        exp_ovf;
  logic        exp_valid = 1'b0;
  logic [63:0] m_r;
  logic        m_o;

  alu_64 dut (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .a       (a),
    .b       (b),
    .ans     (ans),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact arithmetic in 66 bits; overflow means the true result
  // does not fit in a signed 64-bit integer.
  function automatic void model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic o);
    logic signed [65:0] sx, sy, full;
    sx = $signed({{2{x[63]}}, x});
    sy = $signed({{2{y[63]}}, y});
    full = '0;
    o = 1'b0;
    case (c)
      2'd0: full = sx + sy;
      2'd1: full = sx - sy;
      2'd2: full = sx & sy;
      default: full = sx ^ sy;
    endcase
    r = full[63:0];
    if (c < 2'd2) o = (full > SMAX) || (full < SMIN);
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  // Model tracks what the DUT captured at each edge.
  always @(posedge clk) begin
    model(control, a, b, m_r, m_o);
    if (reset) begin
      exp_ans   <= '0;
      exp_ovf   <= 1'b0;
      exp_valid <= 1'b1;
    end else begin
      exp_ans <= m_r;
      exp_ovf <= m_o;
    end
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      check64("model_ans", ans, exp_ans);
      check1("model_ovf", overflow, exp_ovf);
    end
  end

  task automatic step(input string name, input logic [1:0] c, input logic [63:0] x,
                      input logic [63:0] y, input logic [63:0] e_ans, input logic e_ovf);
    control = c;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check64({name, "_ans"}, ans, e_ans);
    check1({name, "_ovf"}, overflow, e_ovf);
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] corners [6];
    corners[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[1] = 64'h8000_0000_0000_0000;
    corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h0;
    corners[4] = 64'h1;
    corners[5] = 64'hC000_0000_0000_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    reset   = 1'b1;
    control = 2'b00;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset_ans", ans, 64'h0);
    check1("reset_ovf", overflow, 1'b0);
    reset = 1'b0;

    step("add_small", 2'b00, 64'd5, 64'd7, 64'd12, 1'b0);
    step("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    step("sub_small", 2'b01, 64'd10, 64'd3, 64'd7, 1'b0);
    step("sub_ovf", 2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    step("sub_neg", 2'b01, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    step("and", 2'b10, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0);
    step("xor", 2'b11, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0);
    step("and_min", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
         64'h8000_0000_0000_0000, 1'b0);
    step("xor_min", 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b0);

    // Back-to-back mix: every edge a different operation.
    step("b2b_add", 2'b00, 64'd1, 64'd2, 64'd3, 1'b0);
    step("b2b_sub", 2'b01, 64'd5, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step("b2b_and", 2'b10, 64'hFF, 64'h0F, 64'h0F, 1'b0);
    step("b2b_xor", 2'b11, 64'hAA, 64'h55, 64'hFF, 1'b0);
    step("b2b_addneg", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step("b2b_subovf", 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'h8000_0000_0000_0000, 1'b1);
    step("b2b_addnovf", 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

    // Mid-stream reset discards the operands at that edge.
    step("pre_rst", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    reset = 1'b1;
    step("mid_rst", 2'b00, 64'd1, 64'd1, 64'h0, 1'b0);
    reset = 1'b0;
    step("post_rst", 2'b00, 64'd1, 64'd1, 64'd2, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      control = 2'($urandom_range(0, 3));
      a = rnd_operand();
      b = rnd_operand();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_64
